// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants and types for the NoC router output-port logic.
//   NUM_PORTS    : number of router input ports (fixed at 5)
//   PORT_N..L    : port index constants (north, east, south, west, local)
//   arb_state_e  : output arbiter FSM state
//   next_ptr     : round-robin pointer advance, wrapping 4 -> 0
//   onehot_idx   : one-hot (5 bit) to binary index
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned PORT_N = 0;
    localparam int unsigned PORT_E = 1;
    localparam int unsigned PORT_S = 2;
    localparam int unsigned PORT_W = 3;
    localparam int unsigned PORT_L = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [4:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// -----------------------------------------------------------------------------
// rr_pick5
// Combinational 5-way round-robin pick: the first set bit of req searching
// upward from index ptr, wrapping 4 -> 0.
//   req    [4:0] in  : requesting ports
//   ptr    [2:0] in  : highest-priority index (0..4)
//   winner [4:0] out : one-hot winner, zero when req == 0
// -----------------------------------------------------------------------------
module rr_pick5 (
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] winner
);

    logic [2:0] w_base;
    logic [3:0] w_sum;
    logic [2:0] w_idx;
    logic       w_found;

    // Out-of-range pointer values cannot occur in the arbiter; fold them to 0
    // so the search stays well defined.
    assign w_base = (ptr > 3'd4) ? 3'd0 : ptr;

    always_comb begin
        winner  = 5'd0;
        w_sum   = 4'd0;
        w_idx   = 3'd0;
        w_found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w_sum = {1'b0, w_base} + 4'(k);
            w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (!w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
// Wormhole output-port arbiter for a 5-port NoC router. One input is locked
// onto the output from head flit to tail flit; a new round-robin decision is
// made only from the idle state, so packets are never interleaved.
//
// Ports:
//   clk         in  : clock, rising edge
//   rst_n       in  : synchronous active-low reset
//   req   [4:0] in  : input i has a front flit routed to this output
//   in_tail [4:0] in: front flit of input i is a tail / single-flit packet
//   out_ready   in  : downstream buffer accepts a flit this cycle
//   grant [4:0] out : registered one-hot mux select, zero when idle
//   rd_en [4:0] out : one-hot pop strobe to the input buffers
//   out_valid   out : downstream write enable
//   pkt_count   out : tail-transfer counter (only with OUT_ARB_PKTCNT_EN)
//
// Build option: define OUT_ARB_PKTCNT_EN to add the pkt_count output and its
// wrapping CNT_W-bit counter. Without it the port and counter are absent.
// -----------------------------------------------------------------------------
module output_port_arbiter #(
    parameter int unsigned NUM_PORTS = 5,  // only 5 is supported
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] in_tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] rd_en,
    output logic                 out_valid
`ifdef OUT_ARB_PKTCNT_EN
    ,
    output logic [CNT_W-1:0]     pkt_count
`endif
);

    import noc_pkg::*;

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic [4:0] r_grant;
    logic [4:0] w_grant_next;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_next;

    logic [4:0] w_winner;
    logic       w_req_g;
    logic       w_tail_g;
    logic       w_xfer;
    logic       w_tail_xfer;

    rr_pick5 u_rr_pick5 (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner)
    );

    // grant is one-hot or zero, so AND-reduce-OR selects the granted bit.
    assign w_req_g     = |(req & r_grant);
    assign w_tail_g    = |(in_tail & r_grant);
    assign w_xfer      = (r_state == ARB_LOCKED) && w_req_g && out_ready;
    assign w_tail_xfer = w_xfer && w_tail_g;

    assign grant     = r_grant;
    assign rd_en     = w_xfer ? r_grant : 5'd0;
    assign out_valid = w_xfer;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        unique case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_state_next = ARB_LOCKED;
                    w_grant_next = w_winner;
                end
            end
            ARB_LOCKED: begin
                // Bubbles and backpressure simply hold the lock.
                if (w_tail_xfer) begin
                    w_state_next = ARB_IDLE;
                    w_grant_next = 5'd0;
                    w_ptr_next   = next_ptr(onehot_idx(r_grant));
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
                w_grant_next = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= 5'd0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_ptr   <= w_ptr_next;
        end
    end

`ifdef OUT_ARB_PKTCNT_EN
    logic [CNT_W-1:0] r_pkt_count;

    // Natural binary overflow gives the all-ones -> 0 wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else if (w_tail_xfer) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_port_arbiter
// Self-checking bench for output_port_arbiter: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a packet-level model
// (locked port index, round-robin pointer, packet count).
// -----------------------------------------------------------------------------
module tb_output_port_arbiter;

`ifdef OUT_ARB_PKTCNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] in_tail;
    logic       out_ready;
    logic [4:0] grant;
    logic [4:0] rd_en;
    logic       out_valid;
`ifdef OUT_ARB_PKTCNT_EN
    logic [TB_CNT_W-1:0] pkt_count;
`endif

    output_port_arbiter #(
        .NUM_PORTS (5),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .rd_en     (rd_en),
        .out_valid (out_valid)
`ifdef OUT_ARB_PKTCNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: -1 means no port holds the output.
    int m_lock = -1;
    int m_ptr  = 0;
    int m_cnt  = 0;
    int m_xfer_port = -1;

    // Last observed DUT values, used by the directed scenarios.
    logic [4:0] g_seen;
    logic [4:0] rd_seen;
    int         cnt_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, compare outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic rn, input logic [4:0] rq, input logic [4:0] tl,
                        input logic rdy);
        logic [4:0] e_grant;
        logic       e_xfer;
        int         n_lock;
        int         n_ptr;
        int         n_cnt;
        @(negedge clk);
        rst_n     = rn;
        req       = rq;
        in_tail   = tl;
        out_ready = rdy;
        #1;
        e_grant = (m_lock < 0) ? 5'd0 : 5'(1 << m_lock);
        e_xfer  = (m_lock >= 0) && rq[m_lock] && rdy;
        check_eq("grant", {27'd0, grant}, {27'd0, e_grant});
        check_eq("rd_en", {27'd0, rd_en}, e_xfer ? {27'd0, e_grant} : 32'd0);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, e_xfer});
`ifdef OUT_ARB_PKTCNT_EN
        check_eq("pkt_count", 32'(pkt_count), 32'(m_cnt));
        cnt_seen = int'(pkt_count);
`else
        cnt_seen = 0;
`endif
        g_seen  = grant;
        rd_seen = rd_en;

        n_lock = m_lock;
        n_ptr  = m_ptr;
        n_cnt  = m_cnt;
        m_xfer_port = e_xfer ? m_lock : -1;
        if (!rn) begin
            n_lock = -1;
            n_ptr  = 0;
            n_cnt  = 0;
        end else if (m_lock < 0) begin
            for (int k = 0; k < 5; k++) begin
                if (n_lock < 0 && rq[(m_ptr + k) % 5]) begin
                    n_lock = (m_ptr + k) % 5;
                end
            end
        end else if (e_xfer && tl[m_lock]) begin
            n_ptr  = (m_lock + 1) % 5;
            n_lock = -1;
            n_cnt  = (m_cnt + 1) % (1 << TB_CNT_W);
        end
        @(posedge clk);
        m_lock = n_lock;
        m_ptr  = n_ptr;
        m_cnt  = n_cnt;
    endtask

    task automatic do_reset();
        step(1'b0, 5'b11111, 5'd0, 1'b0);
        step(1'b0, 5'b11111, 5'd0, 1'b0);
    endtask

    initial begin
        int         heads[$];
        int         holds[$];
        int         fl[5];
        int         cur_hold;
        logic [4:0] prev_g;
        logic [4:0] tl;
        logic [4:0] rq;

        rst_n = 1'b0; req = 5'b11111; in_tail = 5'd0; out_ready = 1'b0;

        // Reset with all ports requesting; then ptr=0 gives port 0 first.
        do_reset();
        check_eq("rst_grant", {27'd0, g_seen}, 32'd0);
        check_eq("rst_rd_en", {27'd0, rd_seen}, 32'd0);
        step(1'b1, 5'b11111, 5'd0, 1'b0);
        step(1'b1, 5'b11111, 5'd0, 1'b0);
        check_eq("first_grant", {27'd0, g_seen}, 32'h01);

        // Single-flit packet on port 2, then ptr=3 favours port 3.
        do_reset();
        step(1'b1, 5'b00100, 5'b00100, 1'b1);
        check_eq("sf_idle", {27'd0, g_seen}, 32'd0);
        step(1'b1, 5'b00000, 5'b00100, 1'b1);
        step(1'b1, 5'b00100, 5'b00100, 1'b1);
        check_eq("sf_grant", {27'd0, g_seen}, 32'h04);
        check_eq("sf_rd_en", {27'd0, rd_seen}, 32'h04);
        step(1'b1, 5'b11111, 5'd0, 1'b1);
        check_eq("sf_back_idle", {27'd0, g_seen}, 32'd0);
        step(1'b1, 5'b11111, 5'd0, 1'b0);
        check_eq("sf_ptr3", {27'd0, g_seen}, 32'h08);

        // Fairness: every port sends repeated 3-flit packets.
        do_reset();
        foreach (fl[i]) fl[i] = 0;
        prev_g = 5'd0;
        cur_hold = 0;
        for (int c = 0; c < 80 && heads.size() < 6; c++) begin
            for (int i = 0; i < 5; i++) tl[i] = (fl[i] == 2);
            step(1'b1, 5'b11111, tl, 1'b1);
            if (g_seen != 5'd0 && prev_g == 5'd0) begin
                for (int i = 0; i < 5; i++) if (g_seen[i]) heads.push_back(i);
                cur_hold = 0;
            end
            if (g_seen == 5'd0 && prev_g != 5'd0) holds.push_back(cur_hold);
            if (rd_seen != 5'd0) cur_hold++;
            if (m_xfer_port >= 0) fl[m_xfer_port] = (fl[m_xfer_port] + 1) % 3;
            prev_g = g_seen;
        end
        check_eq("fair_heads", 32'(heads.size()), 32'd6);
        for (int k = 0; k < heads.size() && k < 6; k++)
            check_eq($sformatf("fair_order%0d", k), 32'(heads[k]), 32'(k % 5));
        for (int k = 0; k < holds.size() && k < 5; k++)
            check_eq($sformatf("fair_hold%0d", k), 32'(holds[k]), 32'd3);

        // Backpressure and bubble on port 1 while port 3 waits.
        do_reset();
        step(1'b1, 5'b01010, 5'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 5'b01010, 5'd0, 1'b0);
            check_eq("bp_grant", {27'd0, g_seen}, 32'h02);
            check_eq("bp_rd_en", {27'd0, rd_seen}, 32'd0);
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 5'b01000, 5'd0, 1'b1);
            check_eq("bub_grant", {27'd0, g_seen}, 32'h02);
            check_eq("bub_rd_en", {27'd0, rd_seen}, 32'd0);
        end
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 5'b01010, (f == 3) ? 5'b00010 : 5'd0, 1'b1);
            check_eq("bp_flit", {27'd0, rd_seen}, 32'h02);
        end
        step(1'b1, 5'b01000, 5'd0, 1'b1);
        check_eq("bp_gap", {27'd0, g_seen}, 32'd0);
        step(1'b1, 5'b01000, 5'd0, 1'b0);
        check_eq("bp_port3", {27'd0, g_seen}, 32'h08);

        // Reset after the 2nd of 4 flits abandons the lock.
        do_reset();
        step(1'b1, 5'b00001, 5'd0, 1'b1);
        step(1'b1, 5'b00001, 5'd0, 1'b1);
        step(1'b1, 5'b00001, 5'd0, 1'b1);
        step(1'b0, 5'b00001, 5'd0, 1'b0);
        step(1'b1, 5'b11111, 5'd0, 1'b1);
        check_eq("mid_rst_grant", {27'd0, g_seen}, 32'd0);
        check_eq("mid_rst_rd_en", {27'd0, rd_seen}, 32'd0);
        step(1'b1, 5'b11111, 5'd0, 1'b0);
        check_eq("mid_rst_ptr0", {27'd0, g_seen}, 32'h01);

`ifdef OUT_ARB_PKTCNT_EN
        // 17 single-flit packets through a 4-bit counter.
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            step(1'b1, 5'b00001, 5'b00001, 1'b1);
            if (p == 16) check_eq("cnt_15", 32'(cnt_seen), 32'd15);
            if (p == 17) check_eq("cnt_wrap0", 32'(cnt_seen), 32'd0);
            step(1'b1, 5'b00001, 5'b00001, 1'b1);
        end
        step(1'b1, 5'b00000, 5'd0, 1'b1);
        check_eq("cnt_1", 32'(cnt_seen), 32'd1);
`endif

        // Randomized traffic; resets are applied with out_ready low.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic rn;
            logic rdy;
            rn  = ($urandom_range(0, 49) != 0);
            rq  = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 5'd0;
            tl  = 5'($urandom) & 5'($urandom);
            rdy = rn && ($urandom_range(0, 3) != 0);
            step(rn, rq, tl, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of input ports competing for this output; only 5 is supported.
REQ-002 Parameter CNT_W, default 16, width of the packet counter (see Configuration).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  5  req[i]=1: input buffer i is non-empty and its front flit is routed to this output.
REQ-006 in_tail  input  5  in_tail[i]=1: front flit of input i is a tail or single-flit packet.
REQ-007 out_ready  input  1  downstream buffer can accept a flit this cycle.
REQ-008 grant  output  5  registered one-hot select for the 5:1 flit mux; all zero when idle.
REQ-009 rd_en  output  5  one-hot pop strobe to input buffers.
REQ-010 out_valid  output  1  write enable to the downstream buffer.

Function
REQ-011 The FSM SHALL have two states: IDLE and LOCKED.
REQ-012 In IDLE with req!=0, the next state SHALL be LOCKED and grant SHALL load the round-robin winner: the first set req bit searching upward from index ptr, wrapping 4->0.
REQ-013 In IDLE with req==0, the state, grant and ptr SHALL hold.
REQ-014 A transfer occurs in LOCKED when req[g] & out_ready, where g is the granted index.
REQ-015 rd_en SHALL equal grant masked by the transfer condition; out_valid SHALL equal |rd_en (combinational from registered state).
REQ-016 A transfer with in_tail[g]=1 SHALL return the FSM to IDLE, clear grant and set ptr=(g+1) mod 5 on the same edge.
REQ-017 In LOCKED, a lapse of req[g] (wormhole bubble) or of out_ready SHALL hold grant with rd_en=0, out_valid=0; other requesters SHALL NOT be granted.
REQ-018 Latency: first flit transfers no earlier than one cycle after req rises; back-to-back packets incur exactly one idle cycle between tail and next head.
REQ-019 Requests from non-granted ports SHALL never produce rd_en or out_valid.
REQ-020 grant SHALL always be zero or one-hot.

Reset
REQ-021 With rst_n=0 at a rising edge: state=IDLE, grant=0, ptr=0 and the packet counter=0; rd_en and out_valid SHALL be 0 while state is IDLE.
REQ-022 Reset asserted mid-packet SHALL abandon the lock with no further rd_en; flit-level recovery is the buffers' responsibility.

Configuration
REQ-023 Macro OUT_ARB_PKTCNT_EN defined: output pkt_count [CNT_W-1:0] SHALL exist, increment on each tail transfer and wrap from all-ones to 0.
REQ-024 Macro undefined: pkt_count port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-025 Package noc_pkg SHALL hold NUM_PORTS, port index constants (PORT_N, PORT_E, PORT_S, PORT_W, PORT_L = 0..4) and the arbiter state enum typedef.
REQ-026 The round-robin search SHALL be a combinational sub-module rr_pick5 (inputs req[4:0], ptr[2:0]; output one-hot winner[4:0]).

Verification
REQ-027 Reset: rst_n=0 for 2 cycles with req=5'b11111 -> grant=0, rd_en=0, out_valid=0 throughout; after release, ptr=0 so first grant=5'b00001.
REQ-028 Single-flit packet: req=5'b00100, in_tail=5'b00100, out_ready=1 -> cycle 1 grant=5'b00100, rd_en=5'b00100 and out_valid=1 for exactly one cycle, then IDLE with ptr=3.
REQ-029 Round-robin fairness: all five ports issue repeated 3-flit packets -> grant order 0,1,2,3,4,0 with each grant held exactly 3 transfer cycles.
REQ-030 Backpressure/bubble: port 1 locked on a 4-flit packet, out_ready=0 for 3 cycles then req[1]=0 for 2 cycles -> grant stays 5'b00010, no rd_en, port 3 requesting is never granted until port 1's tail transfers.
REQ-031 Reset mid-packet: rst_n=0 after the 2nd of 4 flits -> next cycle grant=0, ptr=0, no rd_en.
REQ-032 With OUT_ARB_PKTCNT_EN and CNT_W=4: 17 single-flit packets -> pkt_count reads 15 then wraps to 0 then 1.
